// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM main controller and ALU decoder.
// Holds the state, ALU control, opcode, data-processing cmd and mux-select codes.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned CMD_W    = 4;
  localparam int unsigned RD_W     = 4;
  localparam int unsigned ALUCTL_W = 2;
  localparam int unsigned FLAGW_W  = 2;
  localparam int unsigned SEL_W    = 2;

  // Controller states; codes 10..15 are unreachable and recover to FETCH.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  typedef enum logic [ALUCTL_W-1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctl_e;

  localparam logic [OP_W-1:0] OP_DP  = 2'b00;
  localparam logic [OP_W-1:0] OP_MEM = 2'b01;
  localparam logic [OP_W-1:0] OP_BR  = 2'b10;

  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
  localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;
  localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;
  localparam logic [CMD_W-1:0] CMD_CMN = 4'b1011;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_READDATA  = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RD2    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b10;

  // Compare-style commands only update flags; they never write a register.
  function automatic logic is_compare(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_CMP) || (cmd == CMD_CMN);
  endfunction

endpackage

// File: rtl/multicycle_decoder_if.sv
// Instruction-in / control-out bundle between the instruction register,
// the main controller and CondLogic/datapath.
//   slave  : controller side (consumes Instr, drives all control outputs)
//   master : datapath side (drives Instr, observes control outputs)
interface multicycle_decoder_if;
  import mc_ctrl_pkg::*;

  logic [INSTR_W-1:0]  Instr;
  logic                PCS;
  logic                RegW;
  logic                MemW;
  logic                NoWrite;
  logic [FLAGW_W-1:0]  FlagW;
  logic                IRWrite;
  logic                NextPC;
  logic                AdrSrc;
  logic [SEL_W-1:0]    ResultSrc;
  logic                ALUSrcA;
  logic [SEL_W-1:0]    ALUSrcB;
  logic [ALUCTL_W-1:0] ALUControl;
  logic [SEL_W-1:0]    ImmSrc;
  logic [SEL_W-1:0]    RegSrc;
  logic                Undef;
  logic [STATE_W-1:0]  State;

  modport slave (
    input  Instr,
    output PCS, RegW, MemW, NoWrite, FlagW, IRWrite, NextPC, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Undef, State
  );

  modport master (
    output Instr,
    input  PCS, RegW, MemW, NoWrite, FlagW, IRWrite, NextPC, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Undef, State
  );

endinterface

// File: rtl/alu_decoder.sv
// Combinational data-processing decoder.
//   funct          : Instr[25:20] (I bit, cmd[3:0], S)
//   exec           : controller is in EXECR/EXECI
//   alu_control_c  : ALU operation (ADD outside execute)
//   flag_w_c       : {NZ write, CV write}, zero outside execute
//   no_write_c     : compare-type command (ungated, so the caller can hold it)
//   supported_c    : encoding is implemented
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                exec,
  output logic [ALUCTL_W-1:0] alu_control_c,
  output logic [FLAGW_W-1:0]  flag_w_c,
  output logic                no_write_c,
  output logic                supported_c
);

  logic [CMD_W-1:0] cmd;
  logic             s_bit;
  logic             arith;
  logic             unused_ibit;

  assign cmd         = funct[4:1];
  assign s_bit       = funct[0];
  assign unused_ibit = funct[5];

  // Command lookup; compares are only legal with S set.
  always_comb begin
    alu_control_c = ALU_ADD;
    flag_w_c      = '0;
    no_write_c    = 1'b0;
    supported_c   = 1'b1;
    arith         = 1'b0;
    unique case (cmd)
      CMD_ADD: begin alu_control_c = ALU_ADD; arith = 1'b1; end
      CMD_SUB: begin alu_control_c = ALU_SUB; arith = 1'b1; end
      CMD_AND: alu_control_c = ALU_AND;
      CMD_ORR: alu_control_c = ALU_ORR;
      CMD_CMP: begin
        alu_control_c = ALU_SUB;
        arith         = 1'b1;
        no_write_c    = 1'b1;
        supported_c   = s_bit;
      end
      CMD_CMN: begin
        alu_control_c = ALU_ADD;
        arith         = 1'b1;
        no_write_c    = 1'b1;
        supported_c   = s_bit;
      end
      default: supported_c = 1'b0;
    endcase
    flag_w_c = {s_bit, s_bit & arith};
    if (!exec) begin
      alu_control_c = ALU_ADD;
      flag_w_c      = '0;
    end
  end

endmodule

// File: rtl/multicycle_decoder.sv
// Main controller for the multicycle ARM datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and produces control intent
// for CondLogic plus datapath mux selects. Outputs are combinational from the
// state register and Instr.
//   CLK    : rising-edge clock
//   RESETn : asynchronous active-low reset
//   bus    : Instr in; PCS, RegW, MemW, NoWrite, FlagW, IRWrite, NextPC,
//            AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
//            RegSrc, Undef, State out
module multicycle_decoder
  import mc_ctrl_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESETn,
  multicycle_decoder_if.slave  bus
);

  state_e              state_q;
  state_e              state_d;
  logic [OP_W-1:0]     op;
  logic [FUNCT_W-1:0]  funct;
  logic [RD_W-1:0]     rd;
  logic                exec_c;
  logic                hold_nw_c;
  logic                instr_ok_c;
  logic [ALUCTL_W-1:0] dp_alu_c;
  logic [FLAGW_W-1:0]  dp_flagw_c;
  logic                dp_nowrite_c;
  logic                dp_ok_c;
  logic                unused_instr;

  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign rd    = bus.Instr[15:12];
  assign unused_instr = ^{bus.Instr[31:28], bus.Instr[19:16], bus.Instr[11:0]};

  assign exec_c    = (state_q == S_EXECR) || (state_q == S_EXECI);
  // NoWrite must survive into ALUWB so CondLogic can veto that RegW.
  assign hold_nw_c = exec_c || (state_q == S_ALUWB);

  alu_decoder u_alu_decoder (
    .funct         (funct),
    .exec          (exec_c),
    .alu_control_c (dp_alu_c),
    .flag_w_c      (dp_flagw_c),
    .no_write_c    (dp_nowrite_c),
    .supported_c   (dp_ok_c)
  );

  assign instr_ok_c = (op == OP_MEM) || (op == OP_BR) || ((op == OP_DP) && dp_ok_c);

  // Instruction-format selects follow Op regardless of state.
  assign bus.ImmSrc = op;
  assign bus.RegSrc = {op == OP_MEM, op == OP_BR};
  assign bus.State  = STATE_W'(state_q);

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_d        = S_FETCH;
    bus.PCS        = 1'b0;
    bus.RegW       = 1'b0;
    bus.MemW       = 1'b0;
    bus.NoWrite    = dp_nowrite_c & hold_nw_c;
    bus.FlagW      = dp_flagw_c;
    bus.IRWrite    = 1'b0;
    bus.NextPC     = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_RD2;
    bus.ALUControl = dp_alu_c;
    bus.Undef      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        state_d       = S_DECODE;
        bus.IRWrite   = 1'b1;
        bus.NextPC    = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        if (!instr_ok_c) begin
          state_d   = S_FETCH;
          bus.Undef = 1'b1;
        end else begin
          unique case (op)
            OP_MEM:  state_d = S_MEMADR;
            OP_BR:   state_d = S_BRANCH;
            default: state_d = funct[5] ? S_EXECI : S_EXECR;
          endcase
        end
      end
      S_MEMADR: begin
        state_d        = funct[0] ? S_MEMRD : S_MEMWR;
        bus.ALUSrcB    = SRCB_EXTIMM;
        // U bit picks base+offset or base-offset.
        bus.ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: begin
        state_d    = S_MEMWB;
        bus.AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_READDATA;
        bus.RegW      = 1'b1;
        bus.PCS       = (rd == 4'd15);
      end
      S_MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
      end
      S_EXECR: begin
        state_d     = S_ALUWB;
        bus.ALUSrcB = SRCB_RD2;
      end
      S_EXECI: begin
        state_d     = S_ALUWB;
        bus.ALUSrcB = SRCB_EXTIMM;
      end
      S_ALUWB: begin
        bus.RegW = 1'b1;
        bus.PCS  = (rd == 4'd15);
      end
      S_BRANCH: begin
        bus.ALUSrcB   = SRCB_EXTIMM;
        bus.ResultSrc = RES_ALURESULT;
        bus.PCS       = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Strobes are held off for the whole reset window.
    if (!RESETn) begin
      bus.IRWrite = 1'b0;
      bus.NextPC  = 1'b0;
      bus.RegW    = 1'b0;
      bus.MemW    = 1'b0;
      bus.PCS     = 1'b0;
      bus.FlagW   = '0;
      bus.Undef   = 1'b0;
    end
  end

endmodule
